int_seq: RTL and testbench

INT_SEQ -- requirements
Module: int_seq

---
 rtl/int_seq.sv | 200 ++++++++++++++++++++
 tb/tb_int_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_seq.sv
// int_seq: sequences one fine-interpolator conversion through int_cal
// (load strobe, 17-cycle count enable, wait for the result) and queues
// results in a first-word-fall-through FIFO. Hits that arrive while a
// conversion is in flight are dropped and counted.
// Ports: clk, rst_n (async, active low); hit, int_raw[15:0] request in;
//   int_load[15:0], shift_tri, cal_en to int_cal; cal_stop, int_out[3:0],
//   out_valid from int_cal; res_data[3:0], res_valid, res_ready result
//   stream; busy, drop_cnt[7:0], ovf, err status.
// Build option: define INT_SEQ_TIMEOUT_EN to add a RUN/WAIT watchdog of
//   TIMEOUT_CYC cycles that aborts the conversion and pulses err.
module int_seq #(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hit,
   input  logic [15:0] int_raw,
   output logic [15:0] int_load,
   output logic        shift_tri,
   output logic        cal_en,
   input  logic        cal_stop,
   input  logic [3:0]  int_out,
   input  logic        out_valid,
   output logic [3:0]  res_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        busy,
   output logic [7:0]  drop_cnt,
   output logic        ovf,
   output logic        err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("int_seq: FIFO_DEPTH must be a power of two >= 2");
   end

   // The watchdog counter is 8 bits wide.
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("int_seq: TIMEOUT_CYC must be in 1..255");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_WAIT
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [15:0] load_d;
   logic        shift_d;
   logic        cal_en_d;
   logic        tmo;

   // ---------------------------------------------------------------
   // Optional watchdog
   // ---------------------------------------------------------------
`ifdef INT_SEQ_TIMEOUT_EN
   logic [7:0] wd_q;
   logic       wd_act;

   assign wd_act = (state_q == S_RUN) || (state_q == S_WAIT);
   assign tmo    = wd_act && (wd_q == 8'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q <= 8'd0;
         err  <= 1'b0;
      end else begin
         err <= tmo;
         if (state_q == S_LOAD) begin
            wd_q <= 8'd0;
         end else if (wd_act) begin
            wd_q <= wd_q + 8'd1;
         end
      end
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Conversion FSM
   // ---------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      load_d   = int_load;
      shift_d  = 1'b0;
      cal_en_d = cal_en;
      unique case (state_q)
         S_IDLE: begin
            if (hit) begin
               load_d  = int_raw;
               shift_d = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cal_en_d = 1'b1;
            state_d  = S_RUN;
         end
         S_RUN: begin
            if (cal_stop) begin
               cal_en_d = 1'b0;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (out_valid) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (tmo) begin
         cal_en_d = 1'b0;
         state_d  = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         int_load  <= 16'd0;
         shift_tri <= 1'b0;
         cal_en    <= 1'b0;
      end else begin
         state_q   <= state_d;
         int_load  <= load_d;
         shift_tri <= shift_d;
         cal_en    <= cal_en_d;
      end
   end

   assign busy = (state_q != S_IDLE);

   // Acceptance is judged on the pre-edge state, so a hit on the
   // WAIT->IDLE edge is still a drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= 8'd0;
      end else if (hit && busy && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // ---------------------------------------------------------------
   // Result FIFO (first-word-fall-through, extra wrap bit on pointers)
   // ---------------------------------------------------------------
   logic [3:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_q;
   logic [AW:0] rd_q;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic        ovf_d;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign push  = out_valid;
   assign pop   = res_ready && !empty;
   // A simultaneous pop frees the slot, so only a pop-less push overflows.
   assign ovf_d = push && full && !pop;

   assign res_valid = !empty;
   assign res_data  = empty ? 4'd0 : mem[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         ovf  <= 1'b0;
      end else begin
         ovf <= ovf_d;
         if (pop) begin
            rd_q <= rd_q + PTR_ONE;
         end
         if (push && !ovf_d) begin
            wr_q <= wr_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !ovf_d) begin
         mem[wr_q[AW-1:0]] <= int_out;
      end
   end

endmodule

// File: tb/tb_int_seq.sv
// tb_int_seq: drives int_seq against a cycle-level int_cal stand-in and a
// transaction-level model (fixed conversion latency plus a result queue).
module tb_int_seq;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hit = 1'b0;
   logic [15:0] int_raw = 16'd0;
   logic [15:0] int_load;
   logic        shift_tri;
   logic        cal_en;
   logic        cal_stop;
   logic [3:0]  int_out;
   logic        out_valid;
   logic [3:0]  res_data;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        busy;
   logic [7:0]  drop_cnt;
   logic        ovf;
   logic        err;

   always #2 clk = ~clk;

   int_seq #(
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT_CYC(32)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .hit      (hit),
      .int_raw  (int_raw),
      .int_load (int_load),
      .shift_tri(shift_tri),
      .cal_en   (cal_en),
      .cal_stop (cal_stop),
      .int_out  (int_out),
      .out_valid(out_valid),
      .res_data (res_data),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .busy     (busy),
      .drop_cnt (drop_cnt),
      .ovf      (ovf),
      .err      (err)
   );

   // int_cal result: index of the highest set bit of the loaded vector.
   function automatic logic [3:0] ref_val(input logic [15:0] v);
      ref_val = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) ref_val = 4'(i);
      end
   endfunction

   // int_cal stand-in: latch on shift_tri, stop after 16 enabled cycles,
   // result strobe two cycles after the stop is taken.
   int          cc;
   logic [15:0] cv;
   logic        pend;
   bit          stall = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc        <= 0;
         cv        <= 16'd0;
         pend      <= 1'b0;
         cal_stop  <= 1'b0;
         out_valid <= 1'b0;
         int_out   <= 4'd0;
      end else begin
         out_valid <= pend;
         pend      <= 1'b0;
         if (pend) int_out <= ref_val(cv);
         if (shift_tri) begin
            cv <= int_load;
            cc <= 0;
         end else if (cal_en) begin
            cc <= cc + 1;
            if (cc + 1 == 16 && !stall) cal_stop <= 1'b1;
            if (cc + 1 == 17 && !stall) begin
               cal_stop <= 1'b0;
               pend     <= 1'b1;
            end
         end
      end
   end

   // Transaction model state
   int          t_conv = -1;
   logic [15:0] pend_raw = 16'd0;
   int          drops = 0;
   logic [3:0]  q[$];
   int          ovf_cnt = 0;
   int          sh_cnt = 0;
   int          ce_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, compare after the edge.
   task automatic step(input logic h, input logic [15:0] raw,
                       input logic rdy);
      bit acc;
      bit pop;
      bit push;
      bit xovf;
      hit       = h;
      int_raw   = raw;
      res_ready = rdy;
      acc  = h && (t_conv < 0);
      if (h && t_conv >= 0) drops++;
      pop  = rdy && (q.size() > 0);
      push = 1'b0;
      if (t_conv >= 0) begin
         t_conv++;
         if (t_conv == 20) begin
            push   = 1'b1;
            t_conv = -1;
         end
      end
      xovf = push && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (push && !xovf) q.push_back(ref_val(pend_raw));
      if (acc) begin
         t_conv   = 0;
         pend_raw = raw;
      end
      @(posedge clk);
      #1;
      hit = 1'b0;
      if (ovf) ovf_cnt++;
      if (shift_tri) sh_cnt++;
      if (cal_en) ce_cnt++;
      chk("res_valid", res_valid, q.size() > 0);
      chk("res_data", res_data, (q.size() > 0) ? q[0] : 4'd0);
      chk("busy", busy, t_conv >= 0);
      chk("shift_tri", shift_tri, t_conv == 0);
      chk("cal_en", cal_en, t_conv >= 1 && t_conv <= 17);
      chk("drop_cnt", drop_cnt, (drops > 255) ? 255 : drops);
      chk("ovf", ovf, xovf);
      chk("err", err, 1'b0);
      if (t_conv == 0) chk("int_load", int_load, pend_raw);
   endtask

   // Full conversion; res_ready is raised only on the push edge.
   task automatic conv(input logic [15:0] raw, input logic rdy_at_push);
      step(1'b1, raw, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 16'($urandom), (k == 20) ? rdy_at_push : 1'b0);
      end
   endtask

   initial begin
      int base;
      int e_at;
      int n;

      // Reset values
      #3;
      chk("rst_int_load", int_load, 16'd0);
      chk("rst_shift_tri", shift_tri, 1'b0);
      chk("rst_cal_en", cal_en, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_data", res_data, 4'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drop_cnt", drop_cnt, 8'd0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_err", err, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 00FF: latency, strobe widths, value
      sh_cnt = 0;
      ce_cnt = 0;
      conv(16'h00FF, 1'b0);
      chk("shift_cycles", sh_cnt, 1);
      chk("cal_en_cycles", ce_cnt, 17);
      chk("res_00ff_valid", res_valid, 1'b1);
      chk("res_00ff", res_data, 4'd7);
      step(1'b0, 16'd0, 1'b1);

      conv(16'hFFFF, 1'b0);
      chk("res_ffff", res_data, 4'd15);
      step(1'b0, 16'd0, 1'b1);
      conv(16'h0001, 1'b0);
      chk("res_0001", res_data, 4'd0);
      step(1'b0, 16'd0, 1'b1);

      // Three hits in one conversion, one on the return-to-idle edge
      step(1'b1, 16'h0300, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         step(k == 3 || k == 8 || k == 20, 16'($urandom), 1'b0);
      end
      chk("drop_three", drop_cnt, 8'd3);
      chk("one_result_head", res_data, 4'd9);
      step(1'b0, 16'd0, 1'b1);
      chk("one_result_only", res_valid, 1'b0);

      // Overflow with five conversions, then push+pop while full
      base = ovf_cnt;
      for (int i = 0; i < 5; i++) conv(16'($urandom), 1'b0);
      chk("ovf_once", ovf_cnt - base, 1);
      conv(16'h8000, 1'b1);
      chk("full_push_pop_no_ovf", ovf_cnt - base, 1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 16'd0, 1'b1);
      chk("drained", res_valid, 1'b0);

      // Reset in the middle of RUN
      step(1'b1, 16'h1234, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b0, 16'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cal_en", cal_en, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_res_valid", res_valid, 1'b0);
      chk("mid_rst_drop_cnt", drop_cnt, 8'd0);
      t_conv = -1;
      drops  = 0;
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      conv(16'h0F00, 1'b0);
      chk("post_rst_res", res_data, 4'd11);
      step(1'b0, 16'd0, 1'b1);

      // Random traffic, then a hit burst to saturate drop_cnt
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 7) == 0, 16'($urandom),
              1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 300; i++) step(1'b1, 16'($urandom), 1'b1);
      chk("drop_sat", drop_cnt, 8'hFF);
      for (int i = 0; i < 25; i++) step(1'b0, 16'd0, 1'b1);
      chk("final_empty", res_valid, 1'b0);

`ifdef INT_SEQ_TIMEOUT_EN
      // Watchdog: cal_stop never arrives
      stall = 1'b1;
      hit   = 1'b1;
      @(posedge clk);
      #1;
      hit  = 1'b0;
      e_at = -1;
      n    = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (err) begin
            if (e_at < 0) e_at = k;
            n++;
         end
      end
      chk("tmo_edge", e_at, 33);
      chk("tmo_len", n, 1);
      chk("tmo_busy", busy, 1'b0);
      chk("tmo_cal_en", cal_en, 1'b0);
      chk("tmo_no_push", res_valid, 1'b0);
      stall = 1'b0;
`else
      e_at = 0;
      n    = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
